// File: rtl/fd_pipe_reg_pkg.sv
// Shared constants and the F/D bundle type for the fetch/decode register.
// Exception codes follow the CP0 Cause.ExcCode encoding.
package fd_pipe_reg_pkg;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] PC_RESET = 32'h0000_3000;
   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam logic [31:0] IM_LIMIT = 32'h0000_6FFC;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  exc;
      logic        bd;
      logic        valid;
   } fd_t;

endpackage

// File: rtl/fd_pipe_reg_fetch_exc_chk.sv
// Combinational fetch-address check: flags AdEL on a misaligned PC
// or one outside the instruction memory window.
module fetch_exc_chk
   import fd_pipe_reg_pkg::*;
#(
   parameter logic [31:0] BASE  = IM_BASE,
   parameter logic [31:0] LIMIT = IM_LIMIT,
   parameter logic [4:0]  CODE  = EXC_ADEL
) (
   input  logic [31:0] pc,
   output logic        adel,
   output logic [4:0]  exc_code
);

   always_comb begin
      adel     = (pc[1:0] != 2'b00) || (pc < BASE) || (pc > LIMIT);
      exc_code = adel ? CODE : EXC_NONE;
   end

endmodule

// File: rtl/fd_pipe_reg.sv
// F/D pipeline register with AdEL detection, delay-slot tagging,
// stall/flush bubbles and saturating debug counters.
module fd_pipe_reg
   import fd_pipe_reg_pkg::*;
#(
   parameter logic [31:0] RST_PC  = PC_RESET,
   parameter logic [31:0] BASE    = IM_BASE,
   parameter logic [31:0] LIMIT   = IM_LIMIT,
   parameter logic [4:0]  ADEL_CD = EXC_ADEL,
   parameter int          CNT_W   = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       F_PC,
   input  logic [31:0]       F_Instr,
   input  logic              F_BD,
   input  logic              en,
   input  logic              flush,
   input  logic [31:0]       flush_pc,
   output logic [31:0]       D_PC,
   output logic [31:0]       D_Instr,
   output logic [4:0]        D_ExcCode,
   output logic              D_BD,
   output logic              D_valid,
   output logic [CNT_W-1:0]  cnt_instr,
   output logic [CNT_W-1:0]  cnt_bubble
);

   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   fd_t        d_q;
   logic       adel;
   logic [4:0] f_exc;

   fetch_exc_chk #(
      .BASE  (BASE),
      .LIMIT (LIMIT),
      .CODE  (ADEL_CD)
   ) u_exc (
      .pc       (F_PC),
      .adel     (adel),
      .exc_code (f_exc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         d_q        <= '{pc: RST_PC, instr: NOP, exc: EXC_NONE,
                         bd: 1'b0, valid: 1'b0};
         cnt_instr  <= '0;
         cnt_bubble <= '0;
      end else if (flush) begin
         // flush_pc is a CP0 handler/EPC target; it is not address-checked
         d_q <= '{pc: flush_pc, instr: NOP, exc: EXC_NONE,
                  bd: 1'b0, valid: 1'b0};
         if (cnt_bubble != '1)
            cnt_bubble <= cnt_bubble + ONE;
      end else if (!en) begin
         if (cnt_bubble != '1)
            cnt_bubble <= cnt_bubble + ONE;
      end else begin
         // faulting PC is kept so CP0 can record it as EPC
         d_q <= '{pc: F_PC, instr: adel ? NOP : F_Instr, exc: f_exc,
                  bd: F_BD, valid: 1'b1};
         if (cnt_instr != '1)
            cnt_instr <= cnt_instr + ONE;
      end
   end

   assign D_PC      = d_q.pc;
   assign D_Instr   = d_q.instr;
   assign D_ExcCode = d_q.exc;
   assign D_BD      = d_q.bd;
   assign D_valid   = d_q.valid;

endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- F/D pipeline register directly downstream of the fetch unit in the 5-stage MIPS core.
- Captures the fetched PC and instruction each cycle and detects fetch-address exceptions (AdEL).
- Tags delay-slot instructions and inserts bubbles on stall or flush from the hazard unit and CP0.
- Keeps two saturating debug counters: delivered instructions and bubbles.

Parameters:
- PC_RESET, 32'h0000_3000, D_PC value after reset.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).
- EXC_ADEL, 5'd4, ExcCode reported for an illegal fetch address.
- CNT_W, 32, width of the debug counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- F_PC  in  32  PC of the instruction in F.
- F_Instr  in  32  instruction word returned by external instruction memory.
- F_BD  in  1  F instruction sits in a branch/jump delay slot.
- en  in  1  load enable; 0 means stall/hold, driven by the hazard unit.
- flush  in  1  CP0 exception/interrupt/eret flush request.
- flush_pc  in  32  PC tag written into the bubble on flush.
- D_PC  out  32  registered PC.
- D_Instr  out  32  registered instruction.
- D_ExcCode  out  5  registered exception code; 0 means none.
- D_BD  out  1  registered delay-slot flag.
- D_valid  out  1  1 means D holds a real fetched instruction.
- cnt_instr  out  CNT_W  number of cycles that loaded a valid instruction.
- cnt_bubble  out  CNT_W  number of cycles that inserted a bubble or held on stall.

Behaviour:
- Reset values:
  - D_PC = PC_RESET.
  - D_Instr, D_ExcCode, D_BD, D_valid, cnt_instr, cnt_bubble all 0.
- Update priority on each rising edge: reset > flush > !en > load.
- flush (en is ignored):
  - D_PC = flush_pc; D_Instr = 0 (nop); D_ExcCode = 0; D_BD = 0; D_valid = 0.
  - cnt_bubble += 1.
- Stall (!en && !flush):
  - All D_* outputs hold their values; cnt_bubble += 1.
- Load (en && !flush):
  - D_PC = F_PC; D_BD = F_BD; D_valid = 1; cnt_instr += 1.
  - Fetch exception is adel = (F_PC[1:0] != 0) || (F_PC < IM_BASE) || (F_PC > IM_LIMIT), using unsigned compares.
  - If adel: D_Instr = 0 and D_ExcCode = EXC_ADEL; the PC is still captured so CP0 records the faulting EPC.
  - Otherwise: D_Instr = F_Instr and D_ExcCode = 0.
- Latency: exactly one cycle from F to D. There is no combinational path from inputs to D_* outputs.
- Counters:
  - Unsigned, saturating at all-ones; they never wrap.
  - The cycle in which reset is asserted counts nothing.
- Boundaries:
  - F_PC = IM_LIMIT is legal; IM_LIMIT+4 faults.
  - F_PC = IM_BASE-4 faults.
  - Misalignment alone is sufficient to fault.
  - flush together with !en: flush wins.
  - reset together with flush: reset values are loaded, no count.
  - Reset asserted during a multi-cycle stall clears all state; after release the next load proceeds normally.
  - flush_pc is captured unchecked; no AdEL is raised on the bubble.

Decomposition:
- Shared package/header (extend const.v): EXC_ADEL and the other ExcCode constants, IM_BASE, IM_LIMIT, PC_RESET, NOP encoding 32'h0.
- One natural sub-module: fetch_exc_chk. It is combinational: F_PC in, adel and ExcCode out.
- The stage register and the counters stay in fd_pipe_reg.

Test Plan:
- Reset, then F_PC=0x3000, F_Instr=0x3C010001, en=1 for one cycle -> D_PC=0x3000, D_Instr=0x3C010001, D_ExcCode=0, D_valid=1, cnt_instr=1.
- en=0 for 3 cycles while F_PC changes to 0x3004, 0x3008, 0x300C -> D_* hold 0x3000 values; cnt_bubble=3.
- Address faults:
  - F_PC=0x3002 -> D_ExcCode=4, D_Instr=0, D_PC=0x3002.
  - F_PC=0x7000 -> D_ExcCode=4.
  - F_PC=0x6FFC -> D_ExcCode=0.
  - F_PC=0x2FFC -> D_ExcCode=4.
- F_BD=1, F_PC=0x3010 loaded, then next cycle flush=1 with en=0, flush_pc=0x4180 -> first D_BD=1; then D_PC=0x4180, D_Instr=0, D_BD=0, D_valid=0.
- Preload cnt_instr to max-1 via a long run (CNT_W overridden to 4 in the bench), then 3 loads -> counter saturates at 4'hF.
- Mid-stall reset=1 one cycle -> all outputs at reset values, counters 0; next en=1 load captures normally.
